pc_gen: RTL and testbench

- Fetch-address generator for the RISC-X front end: owns the architectural fetch PC register and drives it to the IF stage.
- Selects the next PC by priority: trap/mret, EX branch resolution, ID jump, predicted branch, sequential.
- Adds a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters so taken branches are predicted in IF and corrected from EX.

---
 rtl/core_pkg.sv | 35 +++
 rtl/pc_gen_btb.sv | 64 ++++++
 rtl/pc_gen.sv | 119 +++++++++++
 tb/tb_pc_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the RISC-X front end: next-PC select encoding and BTB entry layout.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] BTB_CTR_WEAK_TAKEN = 2'b10;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_PRED,
        NPC_JUMP,
        NPC_MISPRED,
        NPC_TRAP
    } npc_sel_t;

    // Tag and target are sized for the widest core; narrower builds zero-extend into them.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        logic [1:0]      ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup port, single update port written at the clock edge.
module btb
    import core_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BTB_ENTRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:1] lookup_pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             upd_valid,
    input  logic [WIDTH-1:1] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t mem [BTB_ENTRIES];

    logic [IDX-1:0]  rd_idx;
    logic [IDX-1:0]  wr_idx;
    logic [XLEN-1:0] rd_tag;
    logic [XLEN-1:0] wr_tag;
    btb_entry_t      rd_entry;
    logic            rd_hit;
    logic            wr_hit;

    assign rd_idx   = lookup_pc[IDX:1];
    assign wr_idx   = upd_pc[IDX:1];
    assign rd_tag   = XLEN'(lookup_pc[WIDTH-1:IDX+1]);
    assign wr_tag   = XLEN'(upd_pc[WIDTH-1:IDX+1]);
    assign rd_entry = mem[rd_idx];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);
    assign wr_hit   = mem[wr_idx].valid && (mem[wr_idx].tag == wr_tag);

    assign pred_taken  = rd_hit && rd_entry.ctr[1];
    assign pred_target = pred_taken ? rd_entry.target[WIDTH-1:0] : '0;

    // A not-taken branch that misses never allocates, so cold entries stay free for taken ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (upd_valid) begin
            if (wr_hit) begin
                mem[wr_idx].ctr <= ctr_next(mem[wr_idx].ctr, upd_taken);
                if (upd_taken) begin
                    mem[wr_idx].target <= XLEN'(upd_target);
                end
            end else if (upd_taken) begin
                mem[wr_idx].valid  <= 1'b1;
                mem[wr_idx].tag    <= wr_tag;
                mem[wr_idx].target <= XLEN'(upd_target);
                mem[wr_idx].ctr    <= BTB_CTR_WEAK_TAKEN;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > EX mispredict > ID jump > BTB prediction > sequential.
// Define RISCX_BTB_EN to build with the branch target buffer; otherwise branches predict not-taken.
module pc_gen
    import core_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               BTB_ENTRIES = 8,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] pc_o,
    output logic             pc_valid_o,
    input  logic             fetch_ready_i,
    input  logic             is_compressed_if_i,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o,
    input  logic             jump_id_i,
    input  logic [WIDTH-1:0] jump_target_id_i,
    input  logic             br_valid_ex_i,
    input  logic [WIDTH-1:0] br_pc_ex_i,
    input  logic             br_compressed_ex_i,
    input  logic             br_taken_ex_i,
    input  logic [WIDTH-1:0] br_target_ex_i,
    input  logic             br_pred_taken_ex_i,
    input  logic [WIDTH-1:0] br_pred_target_ex_i,
    input  logic             trap_i,
    input  logic             is_mret_i,
    input  logic [WIDTH-1:0] mtvec_i,
    input  logic [WIDTH-1:0] mepc_i,
    output logic             flush_o
);

    logic [WIDTH-1:0] pc_q;
    logic             valid_q;
    logic             mispredict;
    logic             redirect;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] mispred_pc;
    logic [WIDTH-1:0] npc;
    npc_sel_t         npc_sel;

`ifdef RISCX_BTB_EN
    btb #(
        .WIDTH       (WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_q[WIDTH-1:1]),
        .pred_taken  (pred_taken_o),
        .pred_target (pred_target_o),
        .upd_valid   (br_valid_ex_i),
        .upd_pc      (br_pc_ex_i[WIDTH-1:1]),
        .upd_taken   (br_taken_ex_i),
        .upd_target  (br_target_ex_i)
    );

    assign mispredict = br_valid_ex_i &&
                        ((br_taken_ex_i != br_pred_taken_ex_i) ||
                         (br_taken_ex_i && (br_target_ex_i != br_pred_target_ex_i)));
`else
    logic unused_pred;

    // Without a BTB nothing is ever predicted taken, so only a taken branch is wrong.
    assign pred_taken_o  = 1'b0;
    assign pred_target_o = '0;
    assign mispredict    = br_valid_ex_i && br_taken_ex_i;
    assign unused_pred   = ^{br_pred_taken_ex_i, br_pred_target_ex_i};
`endif

    assign seq_pc     = pc_q + (is_compressed_if_i ? WIDTH'(2) : WIDTH'(4));
    assign mispred_pc = br_taken_ex_i ? br_target_ex_i
                      : br_pc_ex_i + (br_compressed_ex_i ? WIDTH'(2) : WIDTH'(4));

    always_comb begin
        npc_sel = NPC_SEQ;
        if (trap_i) begin
            npc_sel = NPC_TRAP;
        end else if (mispredict) begin
            npc_sel = NPC_MISPRED;
        end else if (jump_id_i) begin
            npc_sel = NPC_JUMP;
        end else if (pred_taken_o) begin
            npc_sel = NPC_PRED;
        end
    end

    always_comb begin
        npc = seq_pc;
        case (npc_sel)
            NPC_TRAP:    npc = is_mret_i ? mepc_i : mtvec_i;
            NPC_MISPRED: npc = mispred_pc;
            NPC_JUMP:    npc = jump_target_id_i;
            NPC_PRED:    npc = pred_target_o;
            default:     npc = seq_pc;
        endcase
    end

    assign redirect = (npc_sel == NPC_TRAP) || (npc_sel == NPC_MISPRED) || (npc_sel == NPC_JUMP);

    // Redirects move the PC even while IF is stalled; plain advance waits for the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (redirect || (valid_q && fetch_ready_i)) begin
                pc_q <= npc;
            end
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign flush_o    = redirect;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector tables through a scoreboard plus reset corner sequences.
// BTB training steps run only when RISCX_BTB_EN is defined.
module tb_pc_gen;
    import core_pkg::*;

    typedef struct packed {
        logic        rdy;
        logic        comp;
        logic        jmp;
        logic [31:0] jtgt;
        logic        bv;
        logic [31:0] bpc;
        logic        bcomp;
        logic        btaken;
        logic [31:0] btgt;
        logic        bpt;
        logic [31:0] bptgt;
        logic        trap;
        logic        mret;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        exp_flush;
        logic        exp_pt;
        logic [31:0] exp_ptgt;
        logic [31:0] exp_npc;
    } vec_t;

    typedef struct packed {
        logic        flush;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        fetch_ready_i = 1'b0;
    logic        is_compressed_if_i = 1'b0;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        jump_id_i = 1'b0;
    logic [31:0] jump_target_id_i = '0;
    logic        br_valid_ex_i = 1'b0;
    logic [31:0] br_pc_ex_i = '0;
    logic        br_compressed_ex_i = 1'b0;
    logic        br_taken_ex_i = 1'b0;
    logic [31:0] br_target_ex_i = '0;
    logic        br_pred_taken_ex_i = 1'b0;
    logic [31:0] br_pred_target_ex_i = '0;
    logic        trap_i = 1'b0;
    logic        is_mret_i = 1'b0;
    logic [31:0] mtvec_i = '0;
    logic [31:0] mepc_i = '0;
    logic        flush_o;

    int compared   = 0;
    int mismatched = 0;

    exp_t scoreboard[$];
    vec_t mainVecs[$];
    vec_t btbVecs[$];

    pc_gen #(
        .WIDTH       (32),
        .BTB_ENTRIES (8),
        .RESET_PC    (32'h0000_0080)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_o                (pc_o),
        .pc_valid_o          (pc_valid_o),
        .fetch_ready_i       (fetch_ready_i),
        .is_compressed_if_i  (is_compressed_if_i),
        .pred_taken_o        (pred_taken_o),
        .pred_target_o       (pred_target_o),
        .jump_id_i           (jump_id_i),
        .jump_target_id_i    (jump_target_id_i),
        .br_valid_ex_i       (br_valid_ex_i),
        .br_pc_ex_i          (br_pc_ex_i),
        .br_compressed_ex_i  (br_compressed_ex_i),
        .br_taken_ex_i       (br_taken_ex_i),
        .br_target_ex_i      (br_target_ex_i),
        .br_pred_taken_ex_i  (br_pred_taken_ex_i),
        .br_pred_target_ex_i (br_pred_target_ex_i),
        .trap_i              (trap_i),
        .is_mret_i           (is_mret_i),
        .mtvec_i             (mtvec_i),
        .mepc_i              (mepc_i),
        .flush_o             (flush_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        fetch_ready_i       = v.rdy;
        is_compressed_if_i  = v.comp;
        jump_id_i           = v.jmp;
        jump_target_id_i    = v.jtgt;
        br_valid_ex_i       = v.bv;
        br_pc_ex_i          = v.bpc;
        br_compressed_ex_i  = v.bcomp;
        br_taken_ex_i       = v.btaken;
        br_target_ex_i      = v.btgt;
        br_pred_taken_ex_i  = v.bpt;
        br_pred_target_ex_i = v.bptgt;
        trap_i              = v.trap;
        is_mret_i           = v.mret;
        mtvec_i             = v.mtvec;
        mepc_i              = v.mepc;
    endtask

    // Drive one cycle, queue what the DUT should show, then pop and compare before and after the edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        driveInputs(v);
        scoreboard.push_back('{flush: v.exp_flush, pt: v.exp_pt, ptgt: v.exp_ptgt, npc: v.exp_npc});
        #1;
        e = scoreboard.pop_front();
        checkOutput({tag, " flush"}, {31'b0, flush_o}, {31'b0, e.flush});
        checkOutput({tag, " pred_taken"}, {31'b0, pred_taken_o}, {31'b0, e.pt});
        checkOutput({tag, " pred_target"}, pred_target_o, e.ptgt);
        @(posedge clk);
        #1;
        checkOutput({tag, " pc"}, pc_o, e.npc);
    endtask

    task automatic resetAndCheck();
        @(negedge clk);
        driveInputs('0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pc", pc_o, 32'h80);
        checkOutput("reset pc_valid", {31'b0, pc_valid_o}, 32'h0);
        checkOutput("reset flush", {31'b0, flush_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset pc_valid", {31'b0, pc_valid_o}, 32'h1);
        checkOutput("post-reset pc", pc_o, 32'h80);
    endtask

    // Reset in the same cycle as a trap and a mispredict must win and clear the BTB.
    task automatic resetRedirectSeq();
        vec_t v;
        @(negedge clk);
        v = '{default: '0, rdy: 1'b1, trap: 1'b1, mtvec: 32'h300, bv: 1'b1,
              bpc: 32'h120, btaken: 1'b1, btgt: 32'h500};
        driveInputs(v);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst+redirect pc", pc_o, 32'h80);
        checkOutput("rst+redirect pc_valid", {31'b0, pc_valid_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        driveInputs('0);
        #1;
        checkOutput("rst+redirect flush", {31'b0, flush_o}, 32'h0);
        v = '{default: '0, trap: 1'b1, mtvec: 32'h120, exp_flush: 1'b1, exp_npc: 32'h120};
        applyStimulus(v, "trap to trained pc");
        v = '{default: '0, exp_npc: 32'h120};
        applyStimulus(v, "trained pc after reset");
    endtask

    initial begin
        vec_t v;
        mainVecs.push_back('{default: '0, rdy: 1'b1, exp_npc: 32'h84});
        mainVecs.push_back('{default: '0, rdy: 1'b1, exp_npc: 32'h88});
        mainVecs.push_back('{default: '0, rdy: 1'b1, comp: 1'b1, exp_npc: 32'h8A});
        mainVecs.push_back('{default: '0, rdy: 1'b1, exp_npc: 32'h8E});
        mainVecs.push_back('{default: '0, rdy: 1'b1, comp: 1'b1, exp_npc: 32'h90});
        for (int i = 0; i < 3; i++) begin
            mainVecs.push_back('{default: '0, exp_npc: 32'h90});
        end
        mainVecs.push_back('{default: '0, jmp: 1'b1, jtgt: 32'h200, exp_flush: 1'b1, exp_npc: 32'h200});
        mainVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h100, btaken: 1'b1,
                             btgt: 32'h40, exp_flush: 1'b1, exp_npc: 32'h40});
        mainVecs.push_back('{default: '0, rdy: 1'b1, trap: 1'b1, mtvec: 32'h300, bv: 1'b1,
                             bpc: 32'h120, btaken: 1'b1, btgt: 32'h500, exp_flush: 1'b1, exp_npc: 32'h300});
        mainVecs.push_back('{default: '0, rdy: 1'b1, trap: 1'b1, mret: 1'b1, mtvec: 32'h999,
                             mepc: 32'h124, exp_flush: 1'b1, exp_npc: 32'h124});
        mainVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h110, exp_npc: 32'h128});
`ifdef RISCX_BTB_EN
        mainVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h13E, bcomp: 1'b1, bpt: 1'b1,
                             bptgt: 32'h777, exp_flush: 1'b1, exp_npc: 32'h140});
`else
        mainVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h13E, bcomp: 1'b1, bpt: 1'b1,
                             bptgt: 32'h777, exp_npc: 32'h12C});
`endif
        mainVecs.push_back('{default: '0, rdy: 1'b1, jmp: 1'b1, jtgt: 32'h700, bv: 1'b1, bpc: 32'h130,
                             btaken: 1'b1, btgt: 32'h600, exp_flush: 1'b1, exp_npc: 32'h600});
        mainVecs.push_back('{default: '0, rdy: 1'b1, trap: 1'b1, mtvec: 32'hFFFF_FFFC,
                             exp_flush: 1'b1, exp_npc: 32'hFFFF_FFFC});
        mainVecs.push_back('{default: '0, rdy: 1'b1, exp_npc: 32'h0});
        mainVecs.push_back('{default: '0, rdy: 1'b1, comp: 1'b1, exp_npc: 32'h2});
        mainVecs.push_back('{default: '0, bv: 1'b1, bpc: 32'h10, btaken: 1'b1, btgt: 32'h800,
                             exp_flush: 1'b1, exp_npc: 32'h800});
        mainVecs.push_back('{default: '0, exp_npc: 32'h800});

        // Train 0x100 -> 0x40, then decay it with two not-taken resolutions, then train 0x120.
        btbVecs.push_back('{default: '0, rdy: 1'b1, jmp: 1'b1, jtgt: 32'h100, exp_flush: 1'b1, exp_npc: 32'h100});
        btbVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h100, btaken: 1'b1, btgt: 32'h40,
                            exp_flush: 1'b1, exp_npc: 32'h40});
        btbVecs.push_back('{default: '0, rdy: 1'b1, jmp: 1'b1, jtgt: 32'h100, exp_flush: 1'b1, exp_npc: 32'h100});
        btbVecs.push_back('{default: '0, rdy: 1'b1, exp_pt: 1'b1, exp_ptgt: 32'h40, exp_npc: 32'h40});
        btbVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h100, bpt: 1'b1, bptgt: 32'h40,
                            exp_flush: 1'b1, exp_npc: 32'h104});
        btbVecs.push_back('{default: '0, rdy: 1'b1, jmp: 1'b1, jtgt: 32'h100, exp_flush: 1'b1, exp_npc: 32'h100});
        btbVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h100, exp_npc: 32'h104});
        btbVecs.push_back('{default: '0, rdy: 1'b1, bv: 1'b1, bpc: 32'h120, btaken: 1'b1, btgt: 32'h40,
                            exp_flush: 1'b1, exp_npc: 32'h40});
        btbVecs.push_back('{default: '0, rdy: 1'b1, jmp: 1'b1, jtgt: 32'h120, exp_flush: 1'b1, exp_npc: 32'h120});
        btbVecs.push_back('{default: '0, exp_pt: 1'b1, exp_ptgt: 32'h40, exp_npc: 32'h120});
        btbVecs.push_back('{default: '0, exp_pt: 1'b1, exp_ptgt: 32'h40, exp_npc: 32'h120});

        resetAndCheck();
        for (int i = 0; i < mainVecs.size(); i++) begin
            v = mainVecs[i];
            applyStimulus(v, $sformatf("main[%0d]", i));
        end
`ifdef RISCX_BTB_EN
        for (int i = 0; i < btbVecs.size(); i++) begin
            v = btbVecs[i];
            applyStimulus(v, $sformatf("btb[%0d]", i));
        end
`endif
        resetRedirectSeq();

        if (scoreboard.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard drain: got %0d entries expected 0", scoreboard.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
